axis_rotate_sched: RTL

- Packet-level round-robin scheduler that shares one axis_rotate instance between N_SRC AXI-Stream requesters.
- Grants one source per packet and forwards that packet's beats unmodified to the rotator's slave port.
- Latches the source's rotate amount and presents it, stable for the whole packet, as the rotator's config sideband.
- Sits directly upstream of axis_rotate; exercised with the axi_master_model/axi_slave_model bench flow.

---
 rtl/axis_rotate_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axis_rotate_sched.sv
// axis_rotate_sched: packet-level round-robin scheduler sharing one axis_rotate among N_SRC sources.
// Define AXIS_ROTATE_SCHED_STATS_EN to add per-source 16-bit accepted-packet counters (pkt_count).
module axis_rotate_sched #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int ROT_W  = $clog2(DATA_W),
    parameter int SRC_W  = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_SRC-1:0]        s_tvalid,
    output logic [N_SRC-1:0]        s_tready,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    input  logic [N_SRC-1:0]        s_tlast,
    input  logic [N_SRC*ROT_W-1:0]  s_rot_amt,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tlast,
    output logic [SRC_W-1:0]        m_tuser,
    output logic [ROT_W-1:0]        m_rot_amt,
`ifdef AXIS_ROTATE_SCHED_STATS_EN
    output logic                    busy,
    output logic [N_SRC*16-1:0]     pkt_count
`else
    output logic                    busy
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [SRC_W-1:0]  last_q, last_d;
    logic [ROT_W-1:0]  rot_q, rot_d;
    logic [SRC_W-1:0]  pick, cand;
    logic [ROT_W-1:0]  pick_rot;
    logic              hit;
    logic              sel_valid, sel_last, beat_end;
    logic [DATA_W-1:0] sel_data;

    // Search starts one past the previous winner so every source gets a turn.
    always_comb begin
        hit  = 1'b0;
        pick = last_q;
        cand = last_q;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = SRC_W'((int'(last_q) + k) % N_SRC);
            if (!hit && s_tvalid[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        pick_rot  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pick == SRC_W'(i)) begin
                pick_rot = s_rot_amt[i*ROT_W +: ROT_W];
            end
            if (grant_q == SRC_W'(i)) begin
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_data  = s_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        rot_d    = rot_q;
        s_tready = '0;
        busy     = (state_q == BUSY);
        m_tvalid = busy & sel_valid;
        m_tlast  = busy & sel_last;
        m_tdata  = sel_data;
        beat_end = m_tvalid & m_tready & m_tlast;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = BUSY;
                    grant_d = pick;
                    rot_d   = pick_rot;
                end
            end
            BUSY: begin
                s_tready[grant_q] = m_tready;
                if (beat_end) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_tuser   = grant_q;
    assign m_rot_amt = rot_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= SRC_W'(N_SRC - 1);
            rot_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rot_q   <= rot_d;
        end
    end

`ifdef AXIS_ROTATE_SCHED_STATS_EN
    logic [N_SRC-1:0][15:0] cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (beat_end) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 16'd1;
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule
